// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the EX-stage divide controller.
package div_ctrl_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, trial-subtract divisor.
import div_ctrl_pkg::*;

module div_step #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic           nonneg;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    nonneg = (rem_sh >= {1'b0, dvs_i});
    // The true difference is below the divisor, so modulo-2^WIDTH subtraction is exact.
    rem_o  = nonneg ? (rem_sh[WIDTH-1:0] - dvs_i) : rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], nonneg};
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU sequencer: stalls the pipe while busy, pulses valid_o with HI/LO.
// Optional: define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
import div_ctrl_pkg::*;

module div_ctrl #(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             div0_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_comb begin
    abs_a   = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    abs_b   = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    quo_fin = quo_neg_q ? -quo_nx : quo_nx;
    rem_fin = rem_neg_q ? -rem_nx : rem_nx;
  end

  // Results are registered on entry to DONE so lo_o/hi_o are final while valid_o is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    div0_d    = div0_q;
    stall_o   = 1'b0;
    valid_o   = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          stall_o   = 1'b1;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          quo_neg_d = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          rem_neg_d = signed_i & opa_i[WIDTH-1];
          if (opb_i == '0) begin
            lo_d    = {WIDTH{DIV_ZERO_QUO[0]}};
            hi_d    = opa_i;
            div0_d  = 1'b1;
            state_d = DIV_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            lo_d    = '0;
            hi_d    = opa_i;
            div0_d  = 1'b0;
            state_d = DIV_DONE;
          end
`endif
          else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          stall_o = 1'b1;
          rem_d   = rem_nx;
          quo_d   = quo_nx;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            lo_d    = quo_fin;
            hi_d    = rem_fin;
            div0_d  = 1'b0;
            state_d = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        valid_o = !annul_i;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      div0_q    <= div0_d;
    end
  end

  assign lo_o   = lo_q;
  assign hi_o   = hi_q;
  assign div0_o = valid_o & div0_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall, signs, divide-by-zero, annul, reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opa_i, opb_i;
  logic        stall_o, valid_o, div0_o;
  logic [31:0] lo_o, hi_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .lo_o     (lo_o),
    .hi_o     (hi_o),
    .div0_o   (div0_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Entered at posedge+1 with the DUT idle; cycle 0 is the start cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_d0, input int exp_cyc);
    int cyc    = 0;
    int stalls = 0;
    logic seen = 1'b0;
    start_i = 1'b1; signed_i = sgn; opa_i = a; opb_i = b;
    #1;
    while (cyc <= 40) begin
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_cyc));
    check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    check({tag, "_lo"}, lo_o, exp_lo);
    check({tag, "_hi"}, hi_o, exp_hi);
    check({tag, "_div0"}, 32'(div0_o), 32'(exp_d0));
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    check({tag, "_pulse"}, 32'(valid_o), 32'd0);
    check({tag, "_hold_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    int valids;
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opa_i = '0; opb_i = '0;
    #12;
    check("rst_lo", lo_o, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_div0", 32'(div0_o), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_div("div_by0", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);

    // Annul at BUSY cycle 10: stall drops at once, no result, outputs held.
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    #1;
    check("annul_stall", 32'(stall_o), 32'd0);
    check("annul_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    valids = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) valids++;
    end
    check("annul_novalid", 32'(valids), 32'd0);
    check("annul_lo", lo_o, 32'h8000_0000);
    check("annul_hi", hi_o, 32'h0);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);

    // Reset during BUSY cycle 5 clears outputs immediately.
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    check("midrst_stall_pre", 32'(stall_o), 32'd1);
    start_i = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_lo", lo_o, 32'h0);
    check("midrst_hi", hi_o, 32'h0);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", 32'(stall_o), 32'd0);

`ifdef DIV_EARLY_OUT_EN
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1);
`else
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
